fifo_1rw_circ_mem: RTL and testbench

Single-port FIFO built from two modulo-`els_p` circular pointers and one 1RW synchronous-read RAM. Each cycle performs at most one operation, either an enqueue or a dequeue, because the RAM has a single port. Dequeued data appears one cycle after the request. The block is used as a large, area-efficient buffer where one-op-per-cycle throughput is acceptable.

---
 rtl/fifo_1rw_circ_mem_if.sv | 26 ++
 rtl/fifo_1rw_circ_mem.sv | 102 ++++++++++
 tb/tb_fifo_1rw_circ_mem.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_1rw_circ_mem_if.sv
// Operation/status bundle for fifo_1rw_circ_mem: the master issues enqueue/dequeue
// requests, the slave (the FIFO) returns occupancy status and read data.
interface fifo_1rw_circ_mem_if #(
  parameter int unsigned width_p = 8,
  parameter int unsigned els_p   = 16
);
  localparam int unsigned count_width_lp = $clog2(els_p + 1);

  logic [width_p-1:0]        data_i;
  logic                      v_i;
  logic                      enq_not_deq_i;
  logic                      full_o;
  logic                      empty_o;
  logic [count_width_lp-1:0] count_o;
  logic [width_p-1:0]        data_o;

  modport master (
    output data_i, v_i, enq_not_deq_i,
    input  full_o, empty_o, count_o, data_o
  );

  modport slave (
    input  data_i, v_i, enq_not_deq_i,
    output full_o, empty_o, count_o, data_o
  );
endinterface

// File: rtl/fifo_1rw_circ_mem.sv
// One-op-per-cycle FIFO on a single-port synchronous-read RAM with modulo-els_p pointers.
// Optional simulation checks for illegal/unknown requests: define FIFO_1RW_CIRC_MEM_CHECKS_EN.
module fifo_1rw_circ_mem #(
  parameter int unsigned width_p = 8,
  parameter int unsigned els_p   = 16
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  fifo_1rw_circ_mem_if.slave   bus
);
  localparam int unsigned ptr_width_lp   = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int unsigned count_width_lp = $clog2(els_p + 1);
  localparam logic [ptr_width_lp-1:0] last_ptr_lp = ptr_width_lp'(els_p - 1);

  logic [ptr_width_lp-1:0] rd_ptr, wr_ptr;
  logic                    last_op_is_read;
  logic [width_p-1:0]      mem [els_p];

  logic                    ptrs_eq;
  logic                    full, empty;
  logic                    enq_accept, deq_accept;
  logic                    ram_en, ram_we;
  logic [ptr_width_lp-1:0] ram_addr;
  logic [count_width_lp-1:0] count;

  function automatic logic [ptr_width_lp-1:0] ptr_inc(input logic [ptr_width_lp-1:0] p);
    return (p == last_ptr_lp) ? '0 : p + ptr_width_lp'(1);
  endfunction

  // Equal pointers mean empty or full; the last operation tells which.
  assign ptrs_eq = (rd_ptr == wr_ptr);
  assign empty   = ptrs_eq &  last_op_is_read;
  assign full    = ptrs_eq & ~last_op_is_read;

  always_comb begin
    count = '0;
    if (full)
      count = count_width_lp'(els_p);
    else if (wr_ptr > rd_ptr)
      count = count_width_lp'(wr_ptr - rd_ptr);
    else if (!empty)
      count = count_width_lp'(els_p) - count_width_lp'(rd_ptr - wr_ptr);
  end

  assign bus.full_o  = full;
  assign bus.empty_o = empty;
  assign bus.count_o = count;

  // Requests arriving while reset is held must not touch the RAM either.
  assign enq_accept = ~reset_i & bus.v_i &  bus.enq_not_deq_i & ~full;
  assign deq_accept = ~reset_i & bus.v_i & ~bus.enq_not_deq_i & ~empty;
  assign ram_en     = enq_accept | deq_accept;
  assign ram_we     = enq_accept;
  assign ram_addr   = enq_accept ? wr_ptr : rd_ptr;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rd_ptr          <= '0;
      wr_ptr          <= '0;
      last_op_is_read <= 1'b1;
    end else if (enq_accept) begin
      wr_ptr          <= ptr_inc(wr_ptr);
      last_op_is_read <= 1'b0;
    end else if (deq_accept) begin
      rd_ptr          <= ptr_inc(rd_ptr);
      last_op_is_read <= 1'b1;
    end
  end

  // Storage array is intentionally left uninitialised across reset.
  always_ff @(posedge clk_i) begin
    if (ram_en && ram_we)
      mem[ram_addr] <= bus.data_i;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)
      bus.data_o <= '0;
    else if (ram_en && !ram_we)
      bus.data_o <= mem[ram_addr];
  end

`ifdef FIFO_1RW_CIRC_MEM_CHECKS_EN
  always @(posedge clk_i) begin
    if (!reset_i) begin
      if ($isunknown(bus.v_i))
        $error("fifo_1rw_circ_mem: v_i is X/Z");
      else if (bus.v_i) begin
        if ($isunknown(bus.enq_not_deq_i))
          $error("fifo_1rw_circ_mem: enq_not_deq_i is X/Z");
        else if (bus.enq_not_deq_i && full)
          $error("fifo_1rw_circ_mem: enqueue while full");
        else if (!bus.enq_not_deq_i && empty)
          $error("fifo_1rw_circ_mem: dequeue while empty");
      end
    end
  end
`else
  // Rejected operations are dropped silently.
`endif

endmodule

// File: tb/tb_fifo_1rw_circ_mem.sv
// Drives three FIFOs (els_p = 4, 3, 16) with identical requests and compares each
// against a queue-based model of a bounded FIFO with a held read register.
module tb_fifo_1rw_circ_mem;
  logic       clk_i = 1'b0;
  logic       reset_i;
  logic [7:0] data_r;
  logic       v_r;
  logic       enq_r;

  int total = 0;
  int bad   = 0;

  logic [7:0]  mq [3][$];
  logic [7:0]  mdata [3];
  logic [7:0]  obs_data [3];
  logic        obs_full [3];
  logic        obs_empty [3];
  logic [31:0] obs_cnt [3];

  always #5 clk_i = ~clk_i;

  fifo_1rw_circ_mem_if #(.width_p(8), .els_p(4))  if4 ();
  fifo_1rw_circ_mem_if #(.width_p(8), .els_p(3))  if3 ();
  fifo_1rw_circ_mem_if #(.width_p(8), .els_p(16)) if16 ();

  fifo_1rw_circ_mem #(.width_p(8), .els_p(4))  dut4  (.clk_i(clk_i), .reset_i(reset_i), .bus(if4));
  fifo_1rw_circ_mem #(.width_p(8), .els_p(3))  dut3  (.clk_i(clk_i), .reset_i(reset_i), .bus(if3));
  fifo_1rw_circ_mem #(.width_p(8), .els_p(16)) dut16 (.clk_i(clk_i), .reset_i(reset_i), .bus(if16));

  assign if4.data_i  = data_r;  assign if4.v_i  = v_r;  assign if4.enq_not_deq_i  = enq_r;
  assign if3.data_i  = data_r;  assign if3.v_i  = v_r;  assign if3.enq_not_deq_i  = enq_r;
  assign if16.data_i = data_r;  assign if16.v_i = v_r;  assign if16.enq_not_deq_i = enq_r;

  assign obs_data[0] = if4.data_o;   assign obs_full[0] = if4.full_o;
  assign obs_data[1] = if3.data_o;   assign obs_full[1] = if3.full_o;
  assign obs_data[2] = if16.data_o;  assign obs_full[2] = if16.full_o;
  assign obs_empty[0] = if4.empty_o;  assign obs_cnt[0] = 32'(if4.count_o);
  assign obs_empty[1] = if3.empty_o;  assign obs_cnt[1] = 32'(if3.count_o);
  assign obs_empty[2] = if16.empty_o; assign obs_cnt[2] = 32'(if16.count_o);

  function automatic int cap_of(input int k);
    return (k == 0) ? 4 : (k == 1) ? 3 : 16;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 3; k++) begin
      mq[k].delete();
      mdata[k] = 8'h00;
    end
  endtask

  // Present one request for one clock edge; the model applies the same rules.
  task automatic step(input logic v, input logic enq, input logic [7:0] d);
    v_r = v; enq_r = enq; data_r = d;
    for (int k = 0; k < 3; k++) begin
      if (v && enq && mq[k].size() < cap_of(k))
        mq[k].push_back(d);
      else if (v && !enq && mq[k].size() > 0)
        mdata[k] = mq[k].pop_front();
    end
    @(posedge clk_i);
    #1 v_r = 1'b0;
    @(negedge clk_i);
  endtask

  task automatic do_reset();
    @(negedge clk_i) reset_i = 1'b1;
    model_clear();
    @(negedge clk_i) reset_i = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk_i);
    for (int k = 0; k < 3; k++) begin
      total++;
      if (obs_cnt[k] !== 0 || obs_empty[k] !== 1'b1 || obs_full[k] !== 1'b0 || obs_data[k] !== 8'h00) begin
        bad++;
        $display("FAIL reset dut%0d: cnt=%0d empty=%b full=%b data=%h want 0 1 0 00",
                 k, obs_cnt[k], obs_empty[k], obs_full[k], obs_data[k]);
      end
    end
    reset_i = 1'b0;
    @(negedge clk_i);
    step(1'b1, 1'b0, 8'hFF);
    for (int k = 0; k < 3; k++) begin
      total++;
      if (obs_cnt[k] !== 0 || obs_empty[k] !== 1'b1 || obs_full[k] !== 1'b0 || obs_data[k] !== 8'h00) begin
        bad++;
        $display("FAIL deq_on_empty dut%0d: cnt=%0d empty=%b full=%b data=%h want 0 1 0 00",
                 k, obs_cnt[k], obs_empty[k], obs_full[k], obs_data[k]);
      end
    end
  endtask

  task automatic test_fill_overflow();
    logic [7:0] vals [5];
    vals = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b1, vals[i]);
      for (int k = 0; k < 3; k++) begin
        total++;
        if (obs_cnt[k] !== 32'(mq[k].size()) || obs_empty[k] !== (mq[k].size() == 0) ||
            obs_full[k] !== (mq[k].size() == cap_of(k)) || obs_data[k] !== mdata[k]) begin
          bad++;
          $display("FAIL fill[%0d] dut%0d: cnt=%0d empty=%b full=%b data=%h want cnt=%0d data=%h",
                   i, k, obs_cnt[k], obs_empty[k], obs_full[k], obs_data[k], mq[k].size(), mdata[k]);
        end
      end
    end
    total++;
    if (obs_cnt[0] !== 4 || obs_full[0] !== 1'b1) begin
      bad++;
      $display("FAIL full4: cnt=%0d full=%b want 4 1", obs_cnt[0], obs_full[0]);
    end
  endtask

  task automatic test_drain();
    logic [7:0] want4 [4];
    want4 = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, 8'h00);
      total++;
      if (obs_data[0] !== want4[i]) begin
        bad++;
        $display("FAIL drain4[%0d]: data=%h want %h", i, obs_data[0], want4[i]);
      end
      for (int k = 0; k < 3; k++) begin
        total++;
        if (obs_cnt[k] !== 32'(mq[k].size()) || obs_empty[k] !== (mq[k].size() == 0) ||
            obs_full[k] !== (mq[k].size() == cap_of(k)) || obs_data[k] !== mdata[k]) begin
          bad++;
          $display("FAIL drain[%0d] dut%0d: cnt=%0d empty=%b full=%b data=%h want cnt=%0d data=%h",
                   i, k, obs_cnt[k], obs_empty[k], obs_full[k], obs_data[k], mq[k].size(), mdata[k]);
        end
      end
    end
    total++;
    if (obs_empty[0] !== 1'b1) begin
      bad++;
      $display("FAIL drain_empty4: empty=%b want 1", obs_empty[0]);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b1, 8'(8'hA0 + i));
      step(1'b1, 1'b0, 8'h00);
      for (int k = 0; k < 3; k++) begin
        total++;
        if (obs_data[k] !== 8'(8'hA0 + i) || obs_empty[k] !== 1'b1 || obs_cnt[k] !== 0) begin
          bad++;
          $display("FAIL wrap[%0d] dut%0d: data=%h empty=%b cnt=%0d want %h 1 0",
                   i, k, obs_data[k], obs_empty[k], obs_cnt[k], 8'(8'hA0 + i));
        end
      end
    end
  endtask

  task automatic test_interleave();
    step(1'b1, 1'b1, 8'h5A);
    step(1'b1, 1'b1, 8'hC3);
    step(1'b1, 1'b0, 8'h00);
    total++;
    if (obs_cnt[0] !== 1 || obs_data[0] !== 8'h5A) begin
      bad++;
      $display("FAIL two_enq_one_deq: cnt=%0d data=%h want 1 5a", obs_cnt[0], obs_data[0]);
    end
    step(1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b1, 8'h77);
    step(1'b1, 1'b1, 8'h3C);
    for (int k = 0; k < 3; k++) begin
      total++;
      if (obs_data[k] !== 8'h5A || obs_cnt[k] !== 2 || obs_cnt[k] !== 32'(mq[k].size())) begin
        bad++;
        $display("FAIL hold dut%0d: data=%h cnt=%0d want 5a 2", k, obs_data[k], obs_cnt[k]);
      end
    end
    step(1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b0, 8'h00);
    total++;
    if (obs_data[2] !== 8'h3C || obs_empty[2] !== 1'b1) begin
      bad++;
      $display("FAIL interleave_tail: data=%h empty=%b want 3c 1", obs_data[2], obs_empty[2]);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      logic v, enq;
      v   = ($urandom_range(0, 3) != 0);
      enq = (i < 300) ? ($urandom_range(0, 9) < 7) : ($urandom_range(0, 9) < 3);
      step(v, enq, 8'($urandom));
      for (int k = 0; k < 3; k++) begin
        total++;
        if (obs_cnt[k] !== 32'(mq[k].size()) || obs_empty[k] !== (mq[k].size() == 0) ||
            obs_full[k] !== (mq[k].size() == cap_of(k)) || obs_data[k] !== mdata[k]) begin
          bad++;
          $display("FAIL random[%0d] dut%0d: cnt=%0d empty=%b full=%b data=%h want cnt=%0d data=%h",
                   i, k, obs_cnt[k], obs_empty[k], obs_full[k], obs_data[k], mq[k].size(), mdata[k]);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    step(1'b1, 1'b1, 8'h91);
    step(1'b1, 1'b1, 8'h92);
    step(1'b1, 1'b1, 8'h93);
    step(1'b1, 1'b1, 8'h94);
    step(1'b1, 1'b0, 8'h00);
    total++;
    if (obs_cnt[0] !== 3 || obs_data[0] !== 8'h91) begin
      bad++;
      $display("FAIL pre_reset: cnt=%0d data=%h want 3 91", obs_cnt[0], obs_data[0]);
    end
    #2 reset_i = 1'b1;
    model_clear();
    #1;
    for (int k = 0; k < 3; k++) begin
      total++;
      if (obs_empty[k] !== 1'b1 || obs_full[k] !== 1'b0 || obs_cnt[k] !== 0 || obs_data[k] !== 8'h00) begin
        bad++;
        $display("FAIL async_reset dut%0d: empty=%b full=%b cnt=%0d data=%h want 1 0 0 00",
                 k, obs_empty[k], obs_full[k], obs_cnt[k], obs_data[k]);
      end
    end
    @(negedge clk_i) reset_i = 1'b0;
    step(1'b1, 1'b1, 8'hE1);
    step(1'b1, 1'b0, 8'h00);
    for (int k = 0; k < 3; k++) begin
      total++;
      if (obs_data[k] !== 8'hE1 || obs_empty[k] !== 1'b1) begin
        bad++;
        $display("FAIL post_reset dut%0d: data=%h empty=%b want e1 1", k, obs_data[k], obs_empty[k]);
      end
    end
  endtask

  initial begin
    reset_i = 1'b1;
    v_r     = 1'b0;
    enq_r   = 1'b0;
    data_r  = 8'h00;
    model_clear();
    test_reset();
    test_fill_overflow();
    test_drain();
    test_wrap();
    test_interleave();
    test_random();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
